// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the IF/MEM byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam int unsigned REG_BUS_W     = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned RAM_AW_DEF    = 17;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;
  typedef logic [REG_BUS_W-1:0] inst_bus_t;

  localparam reg_bus_t ZERO_WORD = 32'h0000_0000;
  localparam logic     ENABLED   = 1'b1;
  localparam logic     DISABLED  = 1'b0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Latched request attributes kept for the whole operation.
  typedef struct packed {
    logic       is_mem;
    logic [1:0] size;
  } req_t;

  function automatic logic [CNT_W-1:0] byte_count(input logic is_mem, input logic [1:0] size);
    if (!is_mem) return CNT_W'(4);
    case (size)
      SIZE_BYTE: return CNT_W'(1);
      SIZE_HALF: return CNT_W'(2);
      default:   return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_buf.sv
// 4-byte assembly register: whole-word load, per-lane byte write, byte read mux.
module mem_byte_buf
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  reg_bus_t             load_data_i,
  input  logic                 wr_en_i,
  input  logic [1:0]           wr_idx_i,
  input  logic [BYTE_W-1:0]    wr_byte_i,
  input  logic [1:0]           rd_idx_i,
  output logic [BYTE_W-1:0]    rd_byte_c_o,
  output reg_bus_t             word_o
);

  reg_bus_t word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= ZERO_WORD;
    end else if (load_i) begin
      word_q <= load_data_i;
    end else if (wr_en_i) begin
      word_q[BYTE_W*wr_idx_i +: BYTE_W] <= wr_byte_i;
    end
  end

  assign rd_byte_c_o = word_q[BYTE_W*rd_idx_i +: BYTE_W];
  assign word_o      = word_q;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores (MEM first) onto an 8-bit RAM bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW = RAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  reg_bus_t           if_addr_i,
  output inst_bus_t          if_inst_o,
  output logic               if_done_o,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [1:0]         mem_size_i,
  input  reg_bus_t           mem_addr_i,
  input  reg_bus_t           mem_wdata_i,
  output reg_bus_t           mem_rdata_o,
  output logic               mem_done_o,
  output logic               busy_o,
  input  logic [BYTE_W-1:0]  ram_din_i,
  output logic [BYTE_W-1:0]  ram_dout_o,
  output logic [RAM_AW-1:0]  ram_addr_o,
  output logic               ram_wr_o
);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic [RAM_AW-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;

  logic                buf_load, buf_wr_en;
  reg_bus_t            buf_load_data, buf_word;
  logic [1:0]          buf_wr_idx, buf_rd_idx;
  logic [BYTE_W-1:0]   buf_rd_byte;

  logic [CNT_W-1:0]    n_bytes, cnt_inc;
  logic [RAM_AW-1:0]   next_addr;
  logic                unused_addr_hi;

  assign n_bytes   = byte_count(req_q.is_mem, req_q.size);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign next_addr = base_q + RAM_AW'(cnt_inc);
  assign unused_addr_hi = ^{if_addr_i[REG_BUS_W-1:RAM_AW], mem_addr_i[REG_BUS_W-1:RAM_AW]};

  mem_byte_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (buf_load),
    .load_data_i (buf_load_data),
    .wr_en_i     (buf_wr_en),
    .wr_idx_i    (buf_wr_idx),
    .wr_byte_i   (ram_din_i),
    .rd_idx_i    (buf_rd_idx),
    .rd_byte_c_o (buf_rd_byte),
    .word_o      (buf_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= DISABLED;
      if_done_q  <= DISABLED;
      mem_done_q <= DISABLED;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  // Bus outputs are computed one cycle ahead so each byte appears registered.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    ram_addr_d    = '0;
    ram_dout_d    = '0;
    ram_wr_d      = DISABLED;
    if_done_d     = DISABLED;
    mem_done_d    = DISABLED;
    buf_load      = DISABLED;
    buf_load_data = ZERO_WORD;
    buf_wr_en     = DISABLED;
    buf_wr_idx    = 2'(cnt_q - CNT_W'(1));
    buf_rd_idx    = 2'(cnt_inc);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_req_i) begin
          state_d       = mem_we_i ? MEM_WR : MEM_RD;
          req_d.is_mem  = ENABLED;
          req_d.size    = mem_size_i;
          base_d        = mem_addr_i[RAM_AW-1:0];
          ram_addr_d    = mem_addr_i[RAM_AW-1:0];
          ram_wr_d      = mem_we_i;
          ram_dout_d    = mem_we_i ? mem_wdata_i[BYTE_W-1:0] : '0;
          buf_load      = ENABLED;
          buf_load_data = mem_we_i ? mem_wdata_i : ZERO_WORD;
        end else if (if_req_i) begin
          state_d       = IF_RD;
          req_d.is_mem  = DISABLED;
          req_d.size    = SIZE_WORD;
          base_d        = if_addr_i[RAM_AW-1:0];
          ram_addr_d    = if_addr_i[RAM_AW-1:0];
          buf_load      = ENABLED;
        end
      end
      // Address for byte k goes out while byte k-1 returns from RAM.
      IF_RD, MEM_RD: begin
        buf_wr_en = (cnt_q != '0);
        if (cnt_q == n_bytes) begin
          state_d    = DONE;
          if_done_d  = !req_q.is_mem;
          mem_done_d = req_q.is_mem;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < n_bytes) ram_addr_d = next_addr;
        end
      end
      MEM_WR: begin
        if (cnt_inc == n_bytes) begin
          state_d    = DONE;
          mem_done_d = ENABLED;
        end else begin
          cnt_d      = cnt_inc;
          ram_wr_d   = ENABLED;
          ram_addr_d = next_addr;
          ram_dout_d = buf_rd_byte;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == MEM_RD) || (state_q == MEM_WR) ||
                  ((state_q == IDLE) && mem_req_i) ||
                  ((state_q == DONE) && req_q.is_mem);

  assign if_inst_o   = buf_word;
  assign mem_rdata_o = buf_word;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule
